// File: rtl/div_sched_if.sv
// ============================================================================
// Module      : div_sched_if
// Description : Requester-side and divider-side signals of the shared divider
//               scheduler; slave = scheduler, master = requesters plus divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 3
);
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] op_a;
    logic [10*N_REQ-1:0] op_b;
    logic                div_st;
    logic [9:0]          div_f1;
    logic [9:0]          div_f2;
    logic                div_done;
    logic [10:0]         div_f;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [10:0]         rsp_f;
    logic                busy;

    modport slave (
        input  req, op_a, op_b, div_done, div_f,
        output div_st, div_f1, div_f2, gnt, rsp_valid, rsp_id, rsp_f, busy
    );

    modport master (
        output req, op_a, op_b, div_done, div_f,
        input  div_st, div_f1, div_f2, gnt, rsp_valid, rsp_id, rsp_f, busy
    );
endinterface

`default_nettype wire

// File: rtl/div_sched.sv
// ============================================================================
// Module      : div_sched
// Description : Round-robin scheduler sharing one 11-bit mantissa divider
//               among N_REQ requesters; drives the divider's st/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sched #(
    parameter int N_REQ = 4,
    parameter int IDW   = 3
) (
    input  wire logic   clk,
    input  wire logic   reset,
    div_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_SETTLE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [N_REQ-1:0] gnt_q;
    logic             st_q;
    logic [9:0]       f1_q;
    logic [9:0]       f2_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [10:0]      rsp_f_q;

    logic [N_REQ-1:0] req_rot;
    logic             arb_hit;
    logic [IDW-1:0]   arb_id;
    logic [9:0]       sel_a;
    logic [9:0]       sel_b;
    int               slot;

    // Rotating the request vector by ptr turns "first set bit at or after
    // ptr" into "lowest set bit"; the descending loop leaves the lowest one.
    always_comb begin
        req_rot = N_REQ'({bus.req, bus.req} >> ptr_q);
        arb_hit = 1'b0;
        arb_id  = '0;
        slot    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (|(req_rot & (N_REQ'(1) << k))) begin
                slot = int'(ptr_q) + k;
                if (slot >= N_REQ) begin
                    slot = slot - N_REQ;
                end
                arb_hit = 1'b1;
                arb_id  = IDW'(slot);
            end
        end
        sel_a = 10'(bus.op_a >> (10 * int'(arb_id)));
        sel_b = 10'(bus.op_b >> (10 * int'(arb_id)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            st_q        <= 1'b0;
            f1_q        <= '0;
            f2_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_f_q     <= '0;
        end else begin
            st_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (arb_hit) begin
                        f1_q    <= sel_a;
                        f2_q    <= sel_b;
                        id_q    <= arb_id;
                        gnt_q   <= N_REQ'(1) << arb_id;
                        ptr_q   <= (arb_id == IDW'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
                        st_q    <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // The second strobe releases the divider back to its idle state.
                    if (bus.div_done) begin
                        st_q    <= 1'b1;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    rsp_f_q     <= bus.div_f;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    gnt_q       <= '0;
                    state_q     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!bus.div_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_st    = st_q;
    assign bus.div_f1    = f1_q;
    assign bus.div_f2    = f2_q;
    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_div_sched.sv
// ============================================================================
// Module      : tb_div_sched
// Description : Self-checking bench for div_sched with a behavioural divider
//               and a round-robin / fixed-point quotient reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_sched;
    localparam int N_REQ = 4;
    localparam int IDW   = 3;
    localparam int OPW   = 10 * N_REQ;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_sched_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

    div_sched #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference quotient: (1.a / 1.b) in 1.10 fixed point, truncated.
    function automatic logic [10:0] quot(input logic [9:0] a, input logic [9:0] b);
        int n;
        int d;
        n = (1024 + int'(a)) * 1024;
        d = 1024 + int'(b);
        return 11'(n / d);
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
        int s;
        for (int k = 0; k < N_REQ; k++) begin
            s = (p + k) % N_REQ;
            if (|(r & (N_REQ'(1) << s))) return s;
        end
        return -1;
    endfunction

    function automatic logic [9:0] slice10(input logic [OPW-1:0] v, input int i);
        return 10'(v >> (10 * i));
    endfunction

    // Behavioural divider: first st starts, done held until the release st.
    int         lat_min = 6;
    int         lat_max = 6;
    logic       dv_busy;
    int         dv_cnt;
    logic [9:0] dv_a;
    logic [9:0] dv_b;
    initial begin
        bus.div_done = 1'b0;
        bus.div_f    = '0;
    end
    always @(posedge clk) begin
        if (reset) begin
            dv_busy      <= 1'b0;
            dv_cnt       <= 0;
            bus.div_done <= 1'b0;
        end else if (bus.div_done) begin
            if (bus.div_st) bus.div_done <= 1'b0;
        end else if (dv_busy) begin
            if (dv_cnt <= 1) begin
                dv_busy      <= 1'b0;
                bus.div_done <= 1'b1;
                bus.div_f    <= quot(dv_a, dv_b);
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end else if (bus.div_st) begin
            dv_busy <= 1'b1;
            dv_a    <= bus.div_f1;
            dv_b    <= bus.div_f2;
            dv_cnt  <= int'($urandom_range(lat_max, lat_min));
        end
    end

    // Inputs as seen by the DUT at each active edge.
    logic [N_REQ-1:0] req_s;
    logic [OPW-1:0]   opa_s;
    logic [OPW-1:0]   opb_s;
    logic             rst_s;
    always @(posedge clk) begin
        req_s <= bus.req;
        opa_s <= bus.op_a;
        opb_s <= bus.op_b;
        rst_s <= reset;
    end

    // Scoreboard: predict each grant from the sampled requests, then match responses.
    int               ptr_m = 0;
    int               exp_id_q[$];
    logic [10:0]      exp_f_q[$];
    logic [N_REQ-1:0] gnt_prev = '0;
    logic             st_prev = 1'b0;
    logic             done_prev = 1'b0;
    int               cyc = 0;
    int               d_cyc = -100;
    int               st_cnt = 0;
    int               rsp_cnt = 0;
    always @(negedge clk) begin
        int e;
        cyc++;
        if (rst_s) begin
            ptr_m = 0;
            exp_id_q.delete();
            exp_f_q.delete();
            d_cyc = -100;
        end else begin
            if (bus.div_st) begin
                st_cnt++;
                check("st_back_to_back", 32'(st_prev), 0);
            end
            if (bus.gnt != '0 && gnt_prev == '0) begin
                e = rr_pick(req_s, ptr_m);
                check("grant_without_req", 32'(req_s != '0), 1);
                if (e >= 0) begin
                    check("gnt_onehot", 32'(bus.gnt), 32'(1) << e);
                    check("launch_st", 32'(bus.div_st), 1);
                    check("div_f1", 32'(bus.div_f1), 32'(slice10(opa_s, e)));
                    check("div_f2", 32'(bus.div_f2), 32'(slice10(opb_s, e)));
                    exp_id_q.push_back(e);
                    exp_f_q.push_back(quot(slice10(opa_s, e), slice10(opb_s, e)));
                    ptr_m = (e + 1) % N_REQ;
                end
            end
            if (bus.div_done && !done_prev) d_cyc = cyc;
            if (cyc == d_cyc + 1) check("release_st", 32'(bus.div_st), 1);
            if (cyc == d_cyc + 2) check("rsp_latency", 32'(bus.rsp_valid), 1);
            if (bus.rsp_valid) begin
                rsp_cnt++;
                check("rsp_outstanding", 32'(exp_id_q.size()), 1);
                if (exp_id_q.size() > 0) begin
                    check("sb_rsp_id", 32'(bus.rsp_id), 32'(exp_id_q.pop_front()));
                    check("sb_rsp_f", 32'(bus.rsp_f), 32'(exp_f_q.pop_front()));
                end
            end
        end
        gnt_prev  = bus.gnt;
        st_prev   = bus.div_st;
        done_prev = bus.div_done;
    end

    task automatic set_req(input int i, input logic [9:0] a, input logic [9:0] b);
        logic [OPW-1:0] m;
        m = OPW'(10'h3FF) << (10 * i);
        bus.op_a = (bus.op_a & ~m) | (OPW'(a) << (10 * i));
        bus.op_b = (bus.op_b & ~m) | (OPW'(b) << (10 * i));
        bus.req  = bus.req | (N_REQ'(1) << i);
    endtask

    task automatic drop_req(input int i);
        bus.req = bus.req & ~(N_REQ'(1) << i);
    endtask

    task automatic wait_rsp(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
        check({tag, "_rsp_timeout"}, 32'(ok), 1);
    endtask

    task automatic wait_gnt(input int i, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (|(bus.gnt & (N_REQ'(1) << i))) ok = 1'b1;
        end
        check({tag, "_gnt_timeout"}, 32'(ok), 1);
    endtask

    logic [9:0] rr_a[N_REQ] = '{10'h100, 10'h3FF, 10'h000, 10'h2AB};
    logic [9:0] rr_b[N_REQ] = '{10'h080, 10'h000, 10'h3FF, 10'h155};
    int         rr_order[5] = '{0, 1, 2, 3, 0};
    int         pr_order[3] = '{3, 0, 1};

    initial begin
        int s0;
        int r0;
        int g3;
        int rid;
        logic [N_REQ-1:0] bit_i;

        reset    = 1'b1;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_div_st", 32'(bus.div_st), 0);
        check("rst_div_f1", 32'(bus.div_f1), 0);
        check("rst_div_f2", 32'(bus.div_f2), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_id", 32'(bus.rsp_id), 0);
        check("rst_rsp_f", 32'(bus.rsp_f), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        @(negedge clk);

        // Unit divide
        set_req(0, 10'h000, 10'h000);
        s0 = st_cnt;
        wait_rsp("unit");
        check("unit_f", 32'(bus.rsp_f), 32'h400);
        check("unit_id", 32'(bus.rsp_id), 0);
        check("unit_st_pulses", 32'(st_cnt - s0), 2);
        drop_req(0);

        // 1.5 / 1.0
        set_req(1, 10'h200, 10'h000);
        wait_rsp("q15");
        check("q15_f", 32'(bus.rsp_f), 32'h600);
        check("q15_id", 32'(bus.rsp_id), 1);
        drop_req(1);

        // 1.0 / 1.5
        set_req(2, 10'h000, 10'h200);
        wait_rsp("q067");
        check("q067_f", 32'(bus.rsp_f), 32'h2AA);
        check("q067_id", 32'(bus.rsp_id), 2);
        drop_req(2);

        // Reset in the middle of WAIT
        set_req(3, 10'h155, 10'h0AA);
        wait_gnt(3, "midrst");
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drop_req(3);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_gnt", 32'(bus.gnt), 0);
        r0 = rsp_cnt;
        repeat (20) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_cnt - r0), 0);

        // Round-robin with every request held
        for (int i = 0; i < N_REQ; i++) set_req(i, rr_a[i], rr_b[i]);
        for (int k = 0; k < 5; k++) begin
            wait_rsp("rr");
            rid = rr_order[k];
            check("rr_id", 32'(bus.rsp_id), 32'(rid));
            check("rr_f", 32'(bus.rsp_f), 32'(quot(rr_a[rid], rr_b[rid])));
            if (k == 4) bus.req = '0;
        end

        // Requester drops after its own grant: still answered
        set_req(1, 10'h123, 10'h321);
        wait_gnt(1, "dropg");
        drop_req(1);
        wait_rsp("dropg");
        check("dropg_id", 32'(bus.rsp_id), 1);
        check("dropg_f", 32'(bus.rsp_f), 32'(quot(10'h123, 10'h321)));

        // Never-granted requester drops while another is in flight
        set_req(0, 10'h050, 10'h300);
        wait_gnt(0, "nogr");
        set_req(3, 10'h0F0, 10'h00F);
        repeat (2) @(negedge clk);
        drop_req(3);
        wait_rsp("nogr");
        drop_req(0);
        check("nogr_id", 32'(bus.rsp_id), 0);
        g3 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.gnt[3]) g3++;
        end
        check("nogr_never_granted", 32'(g3), 0);
        check("nogr_idle", 32'(bus.busy), 0);

        // ptr=2 with req=1011 serves 3, 0, 1
        set_req(1, 10'h001, 10'h002);
        wait_rsp("pr_setup");
        drop_req(1);
        @(negedge clk);
        set_req(0, 10'h011, 10'h022);
        set_req(1, 10'h3A0, 10'h0A3);
        set_req(3, 10'h2F0, 10'h1E1);
        for (int k = 0; k < 3; k++) begin
            wait_rsp("pr");
            check("pr_id", 32'(bus.rsp_id), 32'(pr_order[k]));
            drop_req(int'(bus.rsp_id));
        end

        // Randomised traffic against the scoreboard
        lat_min = 1;
        lat_max = 8;
        r0 = rsp_cnt;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                bit_i = N_REQ'(1) << i;
                if ((bus.req & bit_i) == '0) begin
                    if ($urandom_range(9, 0) == 0) set_req(i, 10'($urandom), 10'($urandom));
                end else if (bus.rsp_valid && int'(bus.rsp_id) == i) begin
                    if ($urandom_range(1, 0) == 0) drop_req(i);
                end else if ((bus.gnt & bit_i) == '0 && $urandom_range(39, 0) == 0) begin
                    drop_req(i);
                end
            end
        end
        bus.req = '0;
        for (int c = 0; c < 100 && (bus.busy !== 1'b0); c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("rand_drained_busy", 32'(bus.busy), 0);
        check("rand_queue_empty", 32'(exp_id_q.size()), 0);
        check("rand_traffic", 32'(rsp_cnt - r0 > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
